// File: rtl/knap_pkg.sv
// -----------------------------------------------------------------------------
// knap_pkg
// Shared definitions for the knapsack brute-force search controller.
//   N_ITEMS_DEF / VAL_W_DEF : default item count and coefficient width
//   acc_width()             : accumulator width that can never wrap
//   knap_state_t            : controller state encoding
// -----------------------------------------------------------------------------
package knap_pkg;

  localparam int N_ITEMS_DEF = 5;
  localparam int VAL_W_DEF   = 7;

  // A sum of n_items values of val_w bits each fits in val_w + clog2(n+1) bits.
  function automatic int acc_width(input int n_items, input int val_w);
    return val_w + $clog2(n_items + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    EVAL,
    DONE
  } knap_state_t;

endpackage

// File: rtl/knap_constraint_eval.sv
// -----------------------------------------------------------------------------
// knap_constraint_eval
// Combinational feasibility check for one subset.
//   value_sum, weight_sum, volume_sum : accumulated totals (ACC_W)
//   min_value, max_weight, max_volume : limits (VAL_W), zero-extended here
//   valid                             : all three constraints satisfied
// -----------------------------------------------------------------------------
module knap_constraint_eval #(
  parameter int VAL_W = 7,
  parameter int ACC_W = 10
) (
  input  logic [ACC_W-1:0] value_sum,
  input  logic [ACC_W-1:0] weight_sum,
  input  logic [ACC_W-1:0] volume_sum,
  input  logic [VAL_W-1:0] min_value,
  input  logic [VAL_W-1:0] max_weight,
  input  logic [VAL_W-1:0] max_volume,
  output logic             valid
);

  logic [ACC_W-1:0] min_value_ext;
  logic [ACC_W-1:0] max_weight_ext;
  logic [ACC_W-1:0] max_volume_ext;

  assign min_value_ext  = ACC_W'(min_value);
  assign max_weight_ext = ACC_W'(max_weight);
  assign max_volume_ext = ACC_W'(max_volume);

  assign valid = (value_sum  >= min_value_ext)  &&
                 (weight_sum <= max_weight_ext) &&
                 (volume_sum <= max_volume_ext);

endmodule

// File: rtl/knap_search_ctrl.sv
// -----------------------------------------------------------------------------
// knap_search_ctrl
// Serial brute-force knapsack search. Every subset mask is visited in
// ascending order; each subset spends N_ITEMS cycles in ACCUM (one item per
// cycle through a single shared adder set) and one cycle in EVAL.
//
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : begin a search (sampled only in IDLE)
//   abort           : cancel a search in ACCUM/EVAL; results are cleared
//   item_value/weight/volume : packed per-item coefficients, item i at
//                     [i*VAL_W +: VAL_W]; snapshotted when start is accepted
//   min_value, max_weight, max_volume : subset limits (snapshotted)
//   busy            : search in progress (start-accept edge to leaving DONE)
//   done            : one-cycle completion pulse
//   found, best_mask, best_value, valid_count : search results, held in IDLE
//
// Build option: define KNAP_EARLY_EXIT_EN to stop at the first valid subset.
// -----------------------------------------------------------------------------
module knap_search_ctrl
  import knap_pkg::*;
#(
  parameter  int N_ITEMS = N_ITEMS_DEF,
  parameter  int VAL_W   = VAL_W_DEF,
  localparam int ACC_W   = acc_width(N_ITEMS, VAL_W)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [N_ITEMS*VAL_W-1:0] item_value,
  input  logic [N_ITEMS*VAL_W-1:0] item_weight,
  input  logic [N_ITEMS*VAL_W-1:0] item_volume,
  input  logic [VAL_W-1:0]         min_value,
  input  logic [VAL_W-1:0]         max_weight,
  input  logic [VAL_W-1:0]         max_volume,
  output logic                     busy,
  output logic                     done,
  output logic                     found,
  output logic [N_ITEMS-1:0]       best_mask,
  output logic [ACC_W-1:0]         best_value,
  output logic [N_ITEMS:0]         valid_count
);

  localparam int IDX_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_ITEMS - 1);

`ifdef KNAP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  knap_state_t state, state_next;

  // Configuration snapshot taken at start accept.
  logic [N_ITEMS*VAL_W-1:0] cfg_value;
  logic [N_ITEMS*VAL_W-1:0] cfg_weight;
  logic [N_ITEMS*VAL_W-1:0] cfg_volume;
  logic [VAL_W-1:0]         cfg_min_value;
  logic [VAL_W-1:0]         cfg_max_weight;
  logic [VAL_W-1:0]         cfg_max_volume;

  logic [N_ITEMS-1:0] mask;
  logic [IDX_W-1:0]   idx;
  logic [ACC_W-1:0]   value_sum;
  logic [ACC_W-1:0]   weight_sum;
  logic [ACC_W-1:0]   volume_sum;

  logic [VAL_W-1:0] cur_value;
  logic [VAL_W-1:0] cur_weight;
  logic [VAL_W-1:0] cur_volume;
  logic             item_sel;
  logic             subset_valid;
  logic             eval_exit;

  assign cur_value  = cfg_value [int'(idx)*VAL_W +: VAL_W];
  assign cur_weight = cfg_weight[int'(idx)*VAL_W +: VAL_W];
  assign cur_volume = cfg_volume[int'(idx)*VAL_W +: VAL_W];
  assign item_sel   = mask[idx];

  knap_constraint_eval #(
    .VAL_W (VAL_W),
    .ACC_W (ACC_W)
  ) u_eval (
    .value_sum  (value_sum),
    .weight_sum (weight_sum),
    .volume_sum (volume_sum),
    .min_value  (cfg_min_value),
    .max_weight (cfg_max_weight),
    .max_volume (cfg_max_volume),
    .valid      (subset_valid)
  );

  // The last mask always finishes; early exit also finishes on a hit.
  assign eval_exit = (&mask) || (EARLY_EXIT && subset_valid);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ACCUM;
      ACCUM: begin
        if (abort)                 state_next = IDLE;
        else if (idx == IDX_LAST)  state_next = EVAL;
      end
      EVAL: begin
        if (abort)          state_next = IDLE;
        else if (eval_exit) state_next = DONE;
        else                state_next = ACCUM;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  // NOTE: the configuration snapshot is reset along with everything else; it
  // is a handful of flops, not a RAM, so a reset costs nothing and keeps the
  // post-reset state fully defined.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_value      <= '0;
      cfg_weight     <= '0;
      cfg_volume     <= '0;
      cfg_min_value  <= '0;
      cfg_max_weight <= '0;
      cfg_max_volume <= '0;
      mask           <= '0;
      idx            <= '0;
      value_sum      <= '0;
      weight_sum     <= '0;
      volume_sum     <= '0;
      found          <= 1'b0;
      best_mask      <= '0;
      best_value     <= '0;
      valid_count    <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      // done is registered from DONE, so it pulses on the edge DONE is left.
      done <= (state == DONE);

      unique case (state)
        IDLE: begin
          if (start) begin
            cfg_value      <= item_value;
            cfg_weight     <= item_weight;
            cfg_volume     <= item_volume;
            cfg_min_value  <= min_value;
            cfg_max_weight <= max_weight;
            cfg_max_volume <= max_volume;
            mask           <= '0;
            idx            <= '0;
            value_sum      <= '0;
            weight_sum     <= '0;
            volume_sum     <= '0;
            found          <= 1'b0;
            best_mask      <= '0;
            best_value     <= '0;
            valid_count    <= '0;
            busy           <= 1'b1;
          end
        end

        ACCUM: begin
          if (abort) begin
            found       <= 1'b0;
            best_mask   <= '0;
            best_value  <= '0;
            valid_count <= '0;
            busy        <= 1'b0;
          end else begin
            if (item_sel) begin
              value_sum  <= value_sum  + ACC_W'(cur_value);
              weight_sum <= weight_sum + ACC_W'(cur_weight);
              volume_sum <= volume_sum + ACC_W'(cur_volume);
            end
            idx <= idx + 1'b1;
          end
        end

        EVAL: begin
          if (abort) begin
            found       <= 1'b0;
            best_mask   <= '0;
            best_value  <= '0;
            valid_count <= '0;
            busy        <= 1'b0;
          end else begin
            if (subset_valid) begin
              valid_count <= valid_count + 1'b1;
              // Strict '>' keeps the earlier (lower) mask on a tie.
              if (!found || (value_sum > best_value)) begin
                best_mask  <= mask;
                best_value <= value_sum;
                found      <= 1'b1;
              end
            end
            if (!eval_exit) begin
              mask       <= mask + 1'b1;
              idx        <= '0;
              value_sum  <= '0;
              weight_sum <= '0;
              volume_sum <= '0;
            end
          end
        end

        DONE:    busy <= 1'b0;
        default: busy <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_knap_search_ctrl.sv
// -----------------------------------------------------------------------------
// tb_knap_search_ctrl
// Self-checking bench for knap_search_ctrl: directed cases plus randomized
// item sets, compared against a subset-enumeration reference model.
// -----------------------------------------------------------------------------
module tb_knap_search_ctrl;

  localparam int N     = 5;
  localparam int W     = 7;
  localparam int ACC_W = W + $clog2(N + 1);
  localparam int NW    = N * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [NW-1:0] item_value;
  logic [NW-1:0] item_weight;
  logic [NW-1:0] item_volume;
  logic [W-1:0]  min_value;
  logic [W-1:0]  max_weight;
  logic [W-1:0]  max_volume;
  logic          busy;
  logic          done;
  logic          found;
  logic [N-1:0]  best_mask;
  logic [ACC_W-1:0] best_value;
  logic [N:0]    valid_count;

  int checks = 0;
  int errors = 0;

  // Reference model inputs and expectations.
  int m_v[N];
  int m_w[N];
  int m_vol[N];
  int m_min, m_maxw, m_maxv;
  int exp_found, exp_mask, exp_best, exp_count, exp_lat;

  always #5 clk = ~clk;

  knap_search_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .item_value  (item_value),
    .item_weight (item_weight),
    .item_volume (item_volume),
    .min_value   (min_value),
    .max_weight  (max_weight),
    .max_volume  (max_volume),
    .busy        (busy),
    .done        (done),
    .found       (found),
    .best_mask   (best_mask),
    .best_value  (best_value),
    .valid_count (valid_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic apply(input int v[N], input int w[N], input int vo[N],
                       input int mn, input int mw, input int mv);
    for (int i = 0; i < N; i++) begin
      m_v[i]   = v[i];
      m_w[i]   = w[i];
      m_vol[i] = vo[i];
      item_value [i*W +: W] = W'(v[i]);
      item_weight[i*W +: W] = W'(w[i]);
      item_volume[i*W +: W] = W'(vo[i]);
    end
    m_min = mn; m_maxw = mw; m_maxv = mv;
    min_value  = W'(mn);
    max_weight = W'(mw);
    max_volume = W'(mv);
  endtask

  // Enumerate every subset with plain arithmetic and pick the best one.
  task automatic model();
    exp_found = 0; exp_mask = 0; exp_best = 0; exp_count = 0;
    exp_lat   = (1 << N) * (N + 1) + 1;
    for (int m = 0; m < (1 << N); m++) begin
      int sv, sw, so;
      sv = 0; sw = 0; so = 0;
      for (int i = 0; i < N; i++) begin
        if ((m >> i) & 1) begin
          sv += m_v[i]; sw += m_w[i]; so += m_vol[i];
        end
      end
      if (sv >= m_min && sw <= m_maxw && so <= m_maxv) begin
        exp_count++;
        if (exp_found == 0 || sv > exp_best) begin
          exp_best = sv;
          exp_mask = m;
        end
        exp_found = 1;
`ifdef KNAP_EARLY_EXIT_EN
        exp_lat = (m + 1) * (N + 1) + 1;
        break;
`endif
      end
    end
  endtask

  // Run one full search and compare latency and results with the model.
  task automatic run_search(input string name, input bit start_with_abort,
                            input bit abort_in_done);
    int cyc;
    bit seen;
    model();
    @(negedge clk);
    start = 1'b1;
    abort = start_with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check({name, "_busy_start"}, busy, 1);
    // Inputs may change after acceptance; the snapshot must be used.
    item_value  = {$urandom, $urandom};
    item_weight = {$urandom, $urandom};
    item_volume = {$urandom, $urandom};
    min_value   = W'($urandom);
    max_weight  = W'($urandom);
    max_volume  = W'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < exp_lat + 20) begin
      @(negedge clk);
      cyc++;
      abort = abort_in_done && (cyc == exp_lat - 1);
      if (cyc == exp_lat - 1) check({name, "_busy_end"}, busy, 1);
      if (done) seen = 1'b1;
    end
    abort = 1'b0;
    check({name, "_latency"}, cyc, exp_lat);
    check({name, "_found"}, found, exp_found);
    check({name, "_mask"}, best_mask, exp_mask);
    check({name, "_value"}, best_value, exp_best);
    check({name, "_count"}, valid_count, exp_count);
    @(negedge clk);
    check({name, "_done_width"}, done, 0);
    check({name, "_busy_idle"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int done_seen;
    int exp_partial;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    apply('{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_mask", best_mask, 0);
    check("rst_value", best_value, 0);
    check("rst_count", valid_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Standard set.
    apply('{4, 8, 1, 20, 10}, '{28, 8, 27, 18, 27}, '{27, 27, 4, 4, 1}, 30, 50, 50);
    run_search("std", 1'b0, 1'b0);
    check("std_spec_mask", best_mask, 5'b11000);
    check("std_spec_value", best_value, 30);
    repeat (5) @(negedge clk);
    check("std_hold_value", best_value, exp_best);

    // All-pass, with start+abort together and abort during DONE.
    apply('{4, 8, 1, 20, 10}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 0, 50, 50);
    run_search("allpass", 1'b1, 1'b1);

    // Tie between item 0 and item 1 alone.
    apply('{5, 5, 0, 0, 0}, '{30, 30, 0, 0, 0}, '{0, 0, 0, 0, 0}, 5, 40, 127);
    run_search("tie", 1'b0, 1'b0);

    // Randomized item sets and limits.
    for (int t = 0; t < 6; t++) begin
      int rv[N];
      int rw[N];
      int ro[N];
      for (int i = 0; i < N; i++) begin
        rv[i] = $urandom_range(0, 40);
        rw[i] = $urandom_range(0, 40);
        ro[i] = $urandom_range(0, 40);
      end
      apply(rv, rw, ro, $urandom_range(0, 80), $urandom_range(0, 127),
            $urandom_range(0, 127));
      run_search($sformatf("rand%0d", t), 1'b0, 1'b0);
    end

    // Control: restart ignored while busy, then abort.
`ifdef KNAP_EARLY_EXIT_EN
    apply('{4, 8, 1, 20, 10}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 127, 50, 50);
    exp_partial = 0;
`else
    apply('{4, 8, 1, 20, 10}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}, 0, 50, 50);
    exp_partial = 99 / (N + 1);
`endif
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (cyc < 99) begin
      @(negedge clk);
      cyc++;
      start = (cyc == 49);
    end
    start = 1'b0;
    check("ctl_busy_pre", busy, 1);
    check("ctl_partial_count", valid_count, exp_partial);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("ctl_busy_abort", busy, 0);
    check("ctl_found_abort", found, 0);
    check("ctl_count_abort", valid_count, 0);
    check("ctl_value_abort", best_value, 0);
    done_seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("ctl_no_done", done_seen, 0);

    // Reset in the middle of a fresh search.
    apply('{4, 8, 1, 20, 10}, '{28, 8, 27, 18, 27}, '{27, 27, 4, 4, 1}, 0, 127, 127);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_found", found, 0);
    check("mid_rst_count", valid_count, 0);
    check("mid_rst_value", best_value, 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (250) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check("mid_rst_idle", done_seen, 0);

    // A clean search after reset proves the controller is back in IDLE.
    apply('{4, 8, 1, 20, 10}, '{28, 8, 27, 18, 27}, '{27, 27, 4, 4, 1}, 30, 50, 50);
    run_search("post_rst", 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/knap_search_ctrl.md
Name: knap_search_ctrl

Overview:
- Sequential brute-force scheduler for the knapsack constraint datapath.
- Enumerates every subset of N_ITEMS items and accumulates value, weight and volume serially through one shared adder set, one item per cycle.
- Checks each subset against the min-value, max-weight and max-volume limits.
- Reports the best valid subset to the host, with a start/done handshake.

Parameters:
- N_ITEMS, 5, number of items; subset mask width.
- VAL_W, 7, width of each per-item coefficient and of each limit.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request to begin a search; sampled only in IDLE.
- abort  in  1  cancels a search in progress.
- item_value  in  N_ITEMS*VAL_W  packed per-item values; item i is at [i*VAL_W +: VAL_W].
- item_weight  in  N_ITEMS*VAL_W  packed per-item weights, same packing.
- item_volume  in  N_ITEMS*VAL_W  packed per-item volumes, same packing.
- min_value  in  VAL_W  minimum total value for a valid subset.
- max_weight  in  VAL_W  maximum total weight for a valid subset.
- max_volume  in  VAL_W  maximum total volume for a valid subset.
- busy  out  1  high from the start-accept edge until the DONE state is left.
- done  out  1  one-cycle pulse when the search finishes.
- found  out  1  at least one valid subset was seen.
- best_mask  out  N_ITEMS  best subset; bit i = item i.
- best_value  out  ACC_W  total value of best_mask.
- valid_count  out  N_ITEMS+1  number of valid subsets evaluated.

Behaviour:
- Reset:
  - All outputs and internal registers go to 0 and the state goes to IDLE.
  - Reset takes effect mid-search immediately; no done pulse is produced.
- Widths:
  - ACC_W = VAL_W + $clog2(N_ITEMS+1) (10 for the defaults). Accumulators never wrap.
  - Limits are zero-extended to ACC_W before comparison.
- States: IDLE, ACCUM, EVAL, DONE.
- IDLE:
  - On start=1: register item/limit inputs into a config snapshot (inputs may change afterwards).
  - Clear mask, idx, the three sums, found, best_mask, best_value and valid_count.
  - Set busy=1 and go to ACCUM.
- ACCUM:
  - Each cycle, if mask[idx]=1, add the item[idx] coefficients to the three sums; then idx++.
  - When idx=N_ITEMS-1, go to EVAL on the next edge.
- EVAL:
  - valid = (value_sum >= min_value) && (weight_sum <= max_weight) && (volume_sum <= max_volume).
  - If valid: valid_count++.
  - If valid and (!found or value_sum > best_value): best_mask=mask, best_value=value_sum, found=1.
  - Ties keep the earlier (lower) mask.
  - If mask is all ones, go to DONE. Otherwise mask++, clear the sums, idx=0, and go to ACCUM.
- DONE: done=1 for exactly one cycle, then IDLE; busy falls with it.
- Timing: each subset takes N_ITEMS+1 cycles. done is high exactly 2^N_ITEMS*(N_ITEMS+1)+1 cycles after the start-accept edge (193 for the defaults).
- start while busy: ignored.
- abort while busy (ACCUM/EVAL):
  - Next state is IDLE; busy=0; no done pulse.
  - found, best_mask, best_value and valid_count are cleared.
- abort and start together in IDLE: start wins.
- abort in DONE: ignored; done still pulses.
- Result outputs hold their values in IDLE until the next accepted start.

Optional Feature:
- Macro KNAP_EARLY_EXIT_EN.
- Defined: the first valid subset in EVAL goes straight to DONE. valid_count=1 and best_mask is the lowest valid mask. Latency is (mask+1)*(N_ITEMS+1)+1 cycles.
- Undefined: full enumeration as above.

Decomposition:
- Package knap_pkg holds:
  - N_ITEMS and VAL_W defaults;
  - ACC_W derivation;
  - state enum knap_state_t {IDLE, ACCUM, EVAL, DONE}.
- Sub-module knap_constraint_eval: combinational; three sums and three limits in, valid out. This is the shared checker instantiated in EVAL.

Test Plan:
- Standard set:
  - Stimulus: values 4,8,1,20,10; weights 28,8,27,18,27; volumes 27,27,4,4,1; min 30; max weight 50; max volume 50; start.
  - Response: done at cycle 193; found=1; best_mask=5'b11000; best_value=30; valid_count=1.
- All-pass:
  - Stimulus: weights and volumes all 0; min 0; same values.
  - Response: valid_count=32; best_mask=5'b11111; best_value=43.
- Tie:
  - Stimulus: values 5,5,0,0,0; weights 30,30,0,0,0; max weight 40; min 5; max volume 127.
  - Response: best_mask=5'b00001 (item 0 alone, mask 1, wins the tie against item 1 alone, mask 2); best_value=5.
- Control:
  - Stimulus: start again at cycle 50, then abort at cycle 100.
  - Response: the second start is ignored; busy drops the next cycle; no done pulse; found=0; valid_count=0.
  - Then drive rst_n low at cycle 60 of a fresh search: all outputs 0 and the state is IDLE.
- KNAP_EARLY_EXIT_EN:
  - Stimulus: the standard set.
  - Response: done 151 cycles after start; best_mask=5'b11000; valid_count=1.
